// File: rtl/car_detector_pkg.sv
// ---------------------------------------------------------------------------
// car_detector_pkg
// Shared definitions for the east-west car detector.
//   - the four legal light codes, in the order {gns, yns, rns, gew, yew, rew}
//   - one-hot FSM state encodings and the state width
//   - a helper that says whether a light code is one of the legal four
// ---------------------------------------------------------------------------
package car_detector_pkg;

  localparam logic [5:0] GNSL = 6'b100001;
  localparam logic [5:0] YNSL = 6'b010001;
  localparam logic [5:0] GEWL = 6'b001100;
  localparam logic [5:0] YEWL = 6'b001010;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    IDLE   = 3'b001,
    PEND   = 3'b010,
    SERVED = 3'b100
  } state_t;

  // True only for the four codes the light controller is allowed to drive
  function automatic logic isLegalLights(input logic [5:0] code);
    return (code == GNSL) || (code == YNSL) || (code == GEWL) || (code == YEWL);
  endfunction

endpackage

// File: rtl/tl_debounce.sv
// ---------------------------------------------------------------------------
// tl_debounce
// Two-flop synchronizer followed by a consecutive-cycle debouncer.
// Ports:
//   clk      - clock, all updates on the rising edge
//   rst_n    - asynchronous active-low reset
//   i_raw    - raw sensor input, asynchronous to clk
//   o_level  - debounced level, flips after DEB_CYCLES consecutive
//              disagreeing cycles of the synchronized input
// ---------------------------------------------------------------------------
module tl_debounce #(
  parameter int DEB_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_raw,
  output logic o_level
);

  // Count value at which the next disagreeing cycle completes the run
  localparam logic [7:0] LAST_CNT = 8'(DEB_CYCLES - 1);

  logic       r_sync1;
  logic       r_sync2;
  logic       r_level;
  logic [7:0] r_cnt;

  // Synchronizer: nothing downstream looks at i_raw directly
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
    end
  end

  // Debouncer: count consecutive cycles where the synchronized input differs
  // from the held level; the flip happens on the edge that closes the run of
  // DEB_CYCLES, and any agreeing cycle restarts the run from zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_level <= 1'b0;
      r_cnt   <= 8'd0;
    end else if (r_sync2 != r_level) begin
      if (r_cnt == LAST_CNT) begin
        r_level <= r_sync2;
        r_cnt   <= 8'd0;
      end else begin
        r_cnt <= r_cnt + 8'd1;
      end
    end else begin
      r_cnt <= 8'd0;
    end
  end

  assign o_level = r_level;

endmodule

// File: rtl/car_detector.sv
// ---------------------------------------------------------------------------
// car_detector
// Raises a car-waiting request for the east-west approach of a traffic light
// and measures how long that request has been pending.
// Ports:
//   clk          - clock
//   rst_n        - asynchronous active-low reset
//   loop_raw     - raw east-west loop sensor (1 = car present), asynchronous
//   lights       - {gns, yns, rns, gew, yew, rew} from the light controller
//   carew        - 1 while an east-west car is waiting (state PEND)
//   wait_cycles  - cycles spent in the current/most recent PEND, saturating
//   err_illegal  - sticky flag, set when lights carries an illegal code
// ---------------------------------------------------------------------------
module car_detector
  import car_detector_pkg::*;
#(
  parameter int DEB_CYCLES = 4,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             loop_raw,
  input  logic [5:0]       lights,
  output logic             carew,
  output logic [CNT_W-1:0] wait_cycles,
  output logic             err_illegal
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             w_presence;
  logic             w_isGewl;
  state_t           r_state;
  logic [CNT_W-1:0] r_wait;
  logic             r_err;

  tl_debounce #(
    .DEB_CYCLES (DEB_CYCLES)
  ) u_debounce (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_raw   (loop_raw),
    .o_level (w_presence)
  );

  // An illegal code can never equal GEWL, so it behaves as "not GEWL"
  assign w_isGewl = (lights == GEWL);

  // Request FSM plus the wait counter; the counter is cleared on the edge
  // that enters PEND and then advances once per PEND cycle until it pins
  // at its maximum. Outside PEND it keeps the last episode's value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_wait  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_presence) begin
            if (w_isGewl) begin
              r_state <= SERVED;
            end else begin
              r_state <= PEND;
              r_wait  <= '0;
            end
          end
        end
        PEND: begin
          if (r_wait != CNT_MAX) begin
            r_wait <= r_wait + CNT_ONE;
          end
          if (w_isGewl) begin
            r_state <= SERVED;
          end else if (!w_presence) begin
            r_state <= IDLE;
          end
        end
        SERVED: begin
          if (!w_presence) begin
            r_state <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  // Sticky illegal-code flag, only reset clears it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else if (!isLegalLights(lights)) begin
      r_err <= 1'b1;
    end
  end

  // carew is a pure decode of the PEND bit of the one-hot state register
  assign carew       = r_state[1];
  assign wait_cycles = r_wait;
  assign err_illegal = r_err;

endmodule

// File: tb/tb_car_detector.sv
// ---------------------------------------------------------------------------
// tb_car_detector
// Directed-vector bench for car_detector with DEB_CYCLES=4, CNT_W=8.
// ---------------------------------------------------------------------------
module tb_car_detector;
  import car_detector_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       loop_raw;
  logic [5:0] lights;
  logic       carew;
  logic [7:0] wait_cycles;
  logic       err_illegal;

  int checkCount;
  int errorCount;

  car_detector #(
    .DEB_CYCLES (4),
    .CNT_W      (8)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .loop_raw    (loop_raw),
    .lights      (lights),
    .carew       (carew),
    .wait_cycles (wait_cycles),
    .err_illegal (err_illegal)
  );

  // 10-unit clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Safety net so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    errorCount = errorCount + 1;
    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $fatal(1, "[TB] watchdog expired");
  end

  // Single comparison point: counts every check and reports mismatches
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount = checkCount + 1;
    if (observed !== expected) begin
      errorCount = errorCount + 1;
      $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Drive the two functional inputs on the falling edge
  task automatic applyStimulus(input logic loopVal, input logic [5:0] lightsVal);
    @(negedge clk);
    loop_raw = loopVal;
    lights   = lightsVal;
  endtask

  // Advance n rising edges and settle 1 unit past the last one
  task automatic stepCycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
    end
    #1;
  endtask

  initial begin
    checkCount = 0;
    errorCount = 0;
    rst_n      = 1'b0;
    loop_raw   = 1'b0;
    lights     = GNSL;

    // Reset state
    stepCycles(2);
    checkOutput("rst_carew", 32'(carew), 32'd0);
    checkOutput("rst_wait", 32'(wait_cycles), 32'd0);
    checkOutput("rst_err", 32'(err_illegal), 32'd0);
    checkOutput("rst_state", 32'(dut.r_state), 32'(IDLE));

    // Car arrives with north-south green: request at edge 7
    @(negedge clk);
    rst_n    = 1'b1;
    loop_raw = 1'b1;
    stepCycles(6);
    checkOutput("lat_edge6_carew", 32'(carew), 32'd0);
    stepCycles(1);
    checkOutput("lat_edge7_carew", 32'(carew), 32'd1);
    checkOutput("lat_edge7_wait", 32'(wait_cycles), 32'd0);
    stepCycles(5);
    checkOutput("count_5", 32'(wait_cycles), 32'd5);

    // Illegal code for one cycle while pending
    applyStimulus(1'b1, 6'b111111);
    stepCycles(1);
    checkOutput("illegal_err", 32'(err_illegal), 32'd1);
    checkOutput("illegal_state", 32'(dut.r_state), 32'(PEND));
    checkOutput("illegal_wait", 32'(wait_cycles), 32'd6);
    applyStimulus(1'b1, GNSL);
    stepCycles(3);
    checkOutput("illegal_sticky", 32'(err_illegal), 32'd1);
    checkOutput("count_9", 32'(wait_cycles), 32'd9);

    // Long wait: counter pins at 255
    stepCycles(246);
    checkOutput("sat_255", 32'(wait_cycles), 32'd255);
    stepCycles(60);
    checkOutput("sat_hold", 32'(wait_cycles), 32'd255);
    checkOutput("sat_carew", 32'(carew), 32'd1);

    // East-west green serves the car
    applyStimulus(1'b1, GEWL);
    stepCycles(1);
    checkOutput("serve_carew", 32'(carew), 32'd0);
    checkOutput("serve_state", 32'(dut.r_state), 32'(SERVED));
    stepCycles(10);
    checkOutput("serve_hold", 32'(dut.r_state), 32'(SERVED));
    checkOutput("serve_wait_hold", 32'(wait_cycles), 32'd255);

    // Car leaves: back to IDLE after 2+4+1 edges
    applyStimulus(1'b0, GEWL);
    stepCycles(6);
    checkOutput("leave_edge6", 32'(dut.r_state), 32'(SERVED));
    stepCycles(1);
    checkOutput("leave_edge7", 32'(dut.r_state), 32'(IDLE));

    // Three-cycle glitch on the loop never reaches the FSM
    applyStimulus(1'b1, GNSL);
    stepCycles(3);
    applyStimulus(1'b0, GNSL);
    for (int i = 0; i < 10; i++) begin
      stepCycles(1);
      checkOutput("glitch_carew", 32'(carew), 32'd0);
      checkOutput("glitch_state", 32'(dut.r_state), 32'(IDLE));
    end
    checkOutput("glitch_wait_hold", 32'(wait_cycles), 32'd255);

    // New pending episode, then asynchronous reset mid-cycle
    applyStimulus(1'b1, GNSL);
    stepCycles(7);
    checkOutput("pend2_carew", 32'(carew), 32'd1);
    checkOutput("pend2_wait", 32'(wait_cycles), 32'd0);
    stepCycles(3);
    checkOutput("pend2_wait3", 32'(wait_cycles), 32'd3);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("arst_carew", 32'(carew), 32'd0);
    checkOutput("arst_wait", 32'(wait_cycles), 32'd0);
    checkOutput("arst_err", 32'(err_illegal), 32'd0);
    checkOutput("arst_state", 32'(dut.r_state), 32'(IDLE));

    // Release with loop held: request returns at edge 7
    @(negedge clk);
    rst_n = 1'b1;
    stepCycles(6);
    checkOutput("rel_edge6_carew", 32'(carew), 32'd0);
    stepCycles(1);
    checkOutput("rel_edge7_carew", 32'(carew), 32'd1);
    checkOutput("rel_edge7_wait", 32'(wait_cycles), 32'd0);

    // Car leaves unserved: PEND -> IDLE after 2+4+1 edges, count kept
    applyStimulus(1'b0, GNSL);
    stepCycles(6);
    checkOutput("unserved_edge6", 32'(carew), 32'd1);
    stepCycles(1);
    checkOutput("unserved_edge7", 32'(carew), 32'd0);
    checkOutput("unserved_state", 32'(dut.r_state), 32'(IDLE));
    checkOutput("unserved_wait", 32'(wait_cycles), 32'd7);
    stepCycles(3);
    checkOutput("unserved_wait_hold", 32'(wait_cycles), 32'd7);

    // Car arrives while east-west is already green: straight to SERVED
    applyStimulus(1'b1, GEWL);
    stepCycles(7);
    checkOutput("direct_state", 32'(dut.r_state), 32'(SERVED));
    checkOutput("direct_carew", 32'(carew), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
